// File: rtl/rf_multiport_if.sv
// Bus bundle for rf_multiport: the two read ports, the write port, the halt
// request, the cycle counter and the register-dump stream.
//
// Dump stream handshake: a word transfers on a rising clk edge where
// dump_valid and dump_ready are both 1. While dump_valid is 1 and
// dump_ready is 0, the producer holds dump_idx, dump_data and dump_last
// stable. dump_valid never depends on dump_ready.
interface rf_multiport_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int CNT_W  = 32
);
   // read ports
   logic [ADDR_W-1:0] rs_addr;
   logic [ADDR_W-1:0] rt_addr;
   logic [DATA_W-1:0] rs_data;
   logic [DATA_W-1:0] rt_data;
   // write port
   logic              we;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] wr_data;
   // control and status
   logic              hlt;
   logic [CNT_W-1:0]  cycle_count;
   logic              busy;
   // dump stream
   logic              dump_valid;
   logic              dump_ready;
   logic [ADDR_W-1:0] dump_idx;
   logic [DATA_W-1:0] dump_data;
   logic              dump_last;

   // Side that drives addresses, write data, hlt and dump_ready.
   modport master (
      output rs_addr, rt_addr, we, rd_addr, wr_data, hlt, dump_ready,
      input  rs_data, rt_data, cycle_count, busy,
             dump_valid, dump_idx, dump_data, dump_last
   );

   // The register file itself.
   modport slave (
      input  rs_addr, rt_addr, we, rd_addr, wr_data, hlt, dump_ready,
      output rs_data, rt_data, cycle_count, busy,
             dump_valid, dump_idx, dump_data, dump_last
   );
endinterface

// File: rtl/rf_multiport.sv
// rf_multiport: 2-read / 1-write register file with a saturating cycle
// counter and a halt-triggered dump of every register followed by the
// frozen cycle count.
//
// FSM: RUN (normal operation, counter runs) -> DUMP (one word per register)
//      -> CNT (one final word carrying the count) -> HALTED (waits for hlt=0)
//      -> RUN. dbg_state encodes RUN=0, DUMP=1, CNT=2, HALTED=3.
module rf_multiport #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter int CNT_W    = 32,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   rf_multiport_if.slave        bus,
   output logic [1:0]           dbg_state
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DUMP   = 2'd1,
      ST_CNT    = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] ptr_q;
   logic [ADDR_W-1:0] ptr_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              hlt_q;
   logic              hlt_rise;
   logic              busy_int;
   logic              wr_en;
   logic [DATA_W-1:0] regs [DEPTH];
   logic [DATA_W-1:0] cnt_word;
   logic [DATA_W-1:0] dump_word;

   // Writes are only taken when no dump is in flight, so the dump is a
   // consistent snapshot of the file as of the hlt edge.
   assign busy_int = (state_q == ST_DUMP) || (state_q == ST_CNT);
   assign wr_en    = bus.we && !busy_int;
   assign hlt_rise = bus.hlt && !hlt_q;

   // Count word for the final dump beat: low DATA_W bits, zero-extended
   // when the counter is narrower than a register.
   if (CNT_W >= DATA_W) begin : g_cnt_trunc
      assign cnt_word = cnt_q[DATA_W-1:0];
   end else begin : g_cnt_ext
      assign cnt_word = {{(DATA_W - CNT_W){1'b0}}, cnt_q};
   end

   // Register array; address 0 is never written when it is hardwired zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en && !(ZERO_REG != 0 && bus.rd_addr == '0)) begin
         regs[bus.rd_addr] <= bus.wr_data;
      end
   end

   // Read port rs: array read, optional forwarding of an accepted write,
   // and the zero-register override applied last so it always wins.
   always_comb begin
      bus.rs_data = regs[bus.rs_addr];
      if (BYPASS != 0 && wr_en && bus.rd_addr == bus.rs_addr) begin
         bus.rs_data = bus.wr_data;
      end
      if (ZERO_REG != 0 && bus.rs_addr == '0) begin
         bus.rs_data = '0;
      end
   end

   // Read port rt: same behaviour as rs.
   always_comb begin
      bus.rt_data = regs[bus.rt_addr];
      if (BYPASS != 0 && wr_en && bus.rd_addr == bus.rt_addr) begin
         bus.rt_data = bus.wr_data;
      end
      if (ZERO_REG != 0 && bus.rt_addr == '0) begin
         bus.rt_data = '0;
      end
   end

   // Registered copy of hlt, used to detect the level's rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hlt_q <= 1'b0;
      end else begin
         hlt_q <= bus.hlt;
      end
   end

   // Cycle counter: advances only in RUN, freezes on the hlt edge that
   // starts a dump, and sticks at its maximum instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (state_q == ST_RUN && !hlt_rise && cnt_q != CNT_MAX) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // FSM state and dump pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // FSM next state and pointer. The pointer is parked at 0 outside DUMP
   // so every dump starts at register 0. hlt is not looked at in DUMP or
   // CNT, so a started dump always runs to completion.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         ST_RUN: begin
            ptr_d = '0;
            if (hlt_rise) begin
               state_d = ST_DUMP;
            end
         end
         ST_DUMP: begin
            if (bus.dump_ready) begin
               ptr_d = ptr_q + 1'b1;
               if (ptr_q == LAST_IDX) begin
                  state_d = ST_CNT;
               end
            end
         end
         ST_CNT: begin
            ptr_d = '0;
            if (bus.dump_ready) begin
               state_d = ST_HALTED;
            end
         end
         ST_HALTED: begin
            ptr_d = '0;
            if (!bus.hlt) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_RUN;
            ptr_d   = '0;
         end
      endcase
   end

   // Register value presented during DUMP; register 0 is forced to zero
   // when hardwired.
   always_comb begin
      dump_word = regs[ptr_q];
      if (ZERO_REG != 0 && ptr_q == '0) begin
         dump_word = '0;
      end
   end

   // Dump stream outputs, decoded purely from state so they clear the
   // moment reset is asserted.
   always_comb begin
      bus.dump_valid = 1'b0;
      bus.dump_last  = 1'b0;
      bus.dump_idx   = '0;
      bus.dump_data  = '0;
      unique case (state_q)
         ST_DUMP: begin
            bus.dump_valid = 1'b1;
            bus.dump_idx   = ptr_q;
            bus.dump_data  = dump_word;
         end
         ST_CNT: begin
            bus.dump_valid = 1'b1;
            bus.dump_last  = 1'b1;
            bus.dump_data  = cnt_word;
         end
         default: begin
            bus.dump_valid = 1'b0;
         end
      endcase
   end

   assign bus.busy        = busy_int;
   assign bus.cycle_count = cnt_q;
   assign dbg_state       = state_q;

endmodule

// File: tb/tb_rf_multiport.sv
// Bench for rf_multiport. Three instances share one reset:
//   dut_m   - defaults (bypass on, zero register on), receives all stimulus
//   dut_nb  - BYPASS=0, mirrors dut_m's inputs
//   dut_sat - CNT_W=4, free-running, used for counter saturation
// Expected dump words are pushed into exp_q by the driver; a negedge
// monitor compares every presented word and pops on each handshake.
module tb_rf_multiport;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   rf_multiport_if #(.DATA_W(16), .ADDR_W(4), .CNT_W(32)) m_if ();
   rf_multiport_if #(.DATA_W(16), .ADDR_W(4), .CNT_W(32)) nb_if ();
   rf_multiport_if #(.DATA_W(16), .ADDR_W(4), .CNT_W(4))  sat_if ();

   logic [1:0] m_st;
   logic [1:0] nb_st;
   logic [1:0] sat_st;

   rf_multiport #(.DATA_W(16), .ADDR_W(4), .CNT_W(32), .ZERO_REG(1), .BYPASS(1))
      dut_m (.clk(clk), .rst_n(rst_n), .bus(m_if), .dbg_state(m_st));
   rf_multiport #(.DATA_W(16), .ADDR_W(4), .CNT_W(32), .ZERO_REG(1), .BYPASS(0))
      dut_nb (.clk(clk), .rst_n(rst_n), .bus(nb_if), .dbg_state(nb_st));
   rf_multiport #(.DATA_W(16), .ADDR_W(4), .CNT_W(4), .ZERO_REG(1), .BYPASS(1))
      dut_sat (.clk(clk), .rst_n(rst_n), .bus(sat_if), .dbg_state(sat_st));

   assign nb_if.rs_addr    = m_if.rs_addr;
   assign nb_if.rt_addr    = m_if.rt_addr;
   assign nb_if.we         = m_if.we;
   assign nb_if.rd_addr    = m_if.rd_addr;
   assign nb_if.wr_data    = m_if.wr_data;
   assign nb_if.hlt        = m_if.hlt;
   assign nb_if.dump_ready = m_if.dump_ready;

   assign sat_if.rs_addr    = '0;
   assign sat_if.rt_addr    = '0;
   assign sat_if.we         = 1'b0;
   assign sat_if.rd_addr    = '0;
   assign sat_if.wr_data    = '0;
   assign sat_if.hlt        = 1'b0;
   assign sat_if.dump_ready = 1'b0;

   int checks = 0;
   int errors = 0;
   // {dump_last, dump_idx, dump_data}
   logic [20:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (m_if.dump_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dump_extra: got word %0h with nothing expected",
                     {m_if.dump_last, m_if.dump_idx, m_if.dump_data});
         end else begin
            check("dump_word", {43'd0, m_if.dump_last, m_if.dump_idx, m_if.dump_data}, {43'd0, exp_q[0]});
            if (m_if.dump_ready === 1'b1) begin
               void'(exp_q.pop_front());
            end
         end
      end
      if (rst_n === 1'b1) begin
         check("busy_vs_valid", 64'(m_if.busy), 64'(m_if.dump_valid));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] w;
      int n;
      rst_n = 1'b0;
      m_if.we = 1'b0;
      m_if.rd_addr = '0;
      m_if.wr_data = '0;
      m_if.rs_addr = '0;
      m_if.rt_addr = '0;
      m_if.hlt = 1'b0;
      m_if.dump_ready = 1'b0;
      #12;
      // reset state
      check("rst_count", 64'(m_if.cycle_count), 64'd0);
      check("rst_busy", 64'(m_if.busy), 64'd0);
      check("rst_valid", 64'(m_if.dump_valid), 64'd0);
      check("rst_last", 64'(m_if.dump_last), 64'd0);
      check("rst_idx", 64'(m_if.dump_idx), 64'd0);
      check("rst_data", 64'(m_if.dump_data), 64'd0);
      check("rst_sat_count", 64'(sat_if.cycle_count), 64'd0);

      @(negedge clk);
      rst_n = 1'b1;
      tick();                                     // edge 1
      check("first_count", 64'(m_if.cycle_count), 64'd1);
      check("first_sat_count", 64'(sat_if.cycle_count), 64'd1);

      // bypass
      m_if.we = 1'b1; m_if.rd_addr = 4'd3; m_if.wr_data = 16'hBEEF;
      m_if.rs_addr = 4'd3; m_if.rt_addr = 4'd3;
      #1;
      check("bypass_rs", 64'(m_if.rs_data), 64'hBEEF);
      check("bypass_rt", 64'(m_if.rt_data), 64'hBEEF);
      check("nobypass_rs_before", 64'(nb_if.rs_data), 64'h0);
      tick();                                     // edge 2
      check("nobypass_rs_after", 64'(nb_if.rs_data), 64'hBEEF);

      // zero register
      m_if.rd_addr = 4'd0; m_if.wr_data = 16'h1234;
      m_if.rs_addr = 4'd0; m_if.rt_addr = 4'd3;
      #1;
      check("zero_rs_bypass", 64'(m_if.rs_data), 64'h0);
      check("plain_read_rt", 64'(m_if.rt_data), 64'hBEEF);
      m_if.rt_addr = 4'd0;
      #1;
      check("zero_rt_bypass", 64'(m_if.rt_data), 64'h0);
      tick();                                     // edge 3
      check("zero_rs_after", 64'(m_if.rs_data), 64'h0);
      check("zero_rt_after", 64'(m_if.rt_data), 64'h0);

      // fill regs[i] = i*0x0101, edges 4..17 for i=1..14
      for (int i = 1; i <= 14; i++) begin
         m_if.rd_addr = 4'(i);
         m_if.wr_data = 16'(i * 16'h0101);
         tick();
      end
      m_if.rs_addr = 4'd14;
      #1;
      check("read_reg14", 64'(m_if.rs_data), 64'h0E0E);

      // expected dump: 16 registers then the count frozen at 17
      for (int i = 0; i < 16; i++) begin
         w = (i == 0) ? 16'h0000 : 16'(i * 16'h0101);
         exp_q.push_back({1'b0, 4'(i), w});
      end
      exp_q.push_back({1'b1, 4'd0, 16'h0011});

      // write reg 15 on the same edge as the hlt rise (edge 18)
      m_if.rd_addr = 4'd15; m_if.wr_data = 16'h0F0F; m_if.hlt = 1'b1;
      tick();
      check("count_frozen_at_hlt", 64'(m_if.cycle_count), 64'd17);
      check("busy_in_dump", 64'(m_if.busy), 64'd1);
      check("state_dump", 64'(m_st), 64'd1);
      check("sat_count_15", 64'(sat_if.cycle_count), 64'd15);

      // write to reg 5 while busy, toggle ready and hlt
      m_if.we = 1'b1; m_if.rd_addr = 4'd5; m_if.wr_data = 16'hDEAD;
      m_if.rs_addr = 4'd5; m_if.dump_ready = 1'b1; m_if.hlt = 1'b0;
      #1;
      check("no_bypass_while_busy", 64'(m_if.rs_data), 64'h0505);
      n = 0;
      while (n < 80) begin
         tick();
         n++;
         if (!m_if.busy) break;
         m_if.dump_ready = ~m_if.dump_ready;
         m_if.hlt = ~m_if.dump_ready;
         if (n == 3) m_if.we = 1'b0;
      end
      if (m_if.busy) begin
         checks++;
         errors++;
         $display("FAIL dump_timeout: got busy=1 expected busy=0 within 80 cycles");
      end
      m_if.we = 1'b0;
      m_if.hlt = 1'b1;
      #1;
      check("dump_queue_empty", 64'(exp_q.size()), 64'd0);
      check("halted_state", 64'(m_st), 64'd3);
      check("halted_valid", 64'(m_if.dump_valid), 64'd0);
      check("halted_count", 64'(m_if.cycle_count), 64'd17);
      check("busy_write_dropped", 64'(m_if.rs_data), 64'h0505);

      // write accepted in HALTED, counter stays frozen
      m_if.we = 1'b1; m_if.rd_addr = 4'd5; m_if.wr_data = 16'h5A5A;
      tick();
      m_if.we = 1'b0;
      #1;
      check("halted_write", 64'(m_if.rs_data), 64'h5A5A);
      tick();
      check("halted_count_hold", 64'(m_if.cycle_count), 64'd17);
      check("halted_hold_state", 64'(m_st), 64'd3);

      // resume
      m_if.hlt = 1'b0;
      tick();
      check("resume_state", 64'(m_st), 64'd0);
      check("resume_count", 64'(m_if.cycle_count), 64'd17);
      tick();
      check("resume_count_inc", 64'(m_if.cycle_count), 64'd18);

      // second dump, reset while word 7 is presented
      for (int i = 0; i < 7; i++) begin
         w = (i == 0) ? 16'h0000 : ((i == 5) ? 16'h5A5A : 16'(i * 16'h0101));
         exp_q.push_back({1'b0, 4'(i), w});
      end
      m_if.dump_ready = 1'b1;
      m_if.hlt = 1'b1;
      tick();
      for (int i = 0; i < 7; i++) tick();
      check("word7_idx", 64'(m_if.dump_idx), 64'd7);
      check("word7_data", 64'(m_if.dump_data), 64'h0707);
      check("sat_count_stays_15", 64'(sat_if.cycle_count), 64'd15);
      rst_n = 1'b0;
      m_if.hlt = 1'b0;
      #1;
      check("abort_busy", 64'(m_if.busy), 64'd0);
      check("abort_valid", 64'(m_if.dump_valid), 64'd0);
      check("abort_count", 64'(m_if.cycle_count), 64'd0);
      check("abort_idx", 64'(m_if.dump_idx), 64'd0);
      check("abort_data", 64'(m_if.dump_data), 64'd0);
      check("abort_sat_count", 64'(sat_if.cycle_count), 64'd0);
      check("abort_queue_empty", 64'(exp_q.size()), 64'd0);
      for (int i = 0; i < 16; i++) begin
         m_if.rs_addr = 4'(i);
         #1;
         check("reset_reg_zero", 64'(m_if.rs_data), 64'd0);
      end

      // clean restart after reset
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("restart_count", 64'(m_if.cycle_count), 64'd1);
      check("restart_state", 64'(m_st), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rf_multiport.md
RF_MULTIPORT -- requirements
Module: rf_multiport

Interface
REQ-001 Parameter DATA_W, default 16: register width in bits.
REQ-002 Parameter ADDR_W, default 4: address width; depth = 2**ADDR_W.
REQ-003 Parameter CNT_W, default 32: cycle-counter width.
REQ-004 Parameter ZERO_REG, default 1: when 1, register 0 reads as 0 and ignores writes.
REQ-005 Parameter BYPASS, default 1: when 1, a same-cycle write to a read address is forwarded to the read output.
REQ-006 Port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-007 Port rst_n  input  1  asynchronous active-low reset.
REQ-008 Port rs_addr, rt_addr  input  ADDR_W  read-port addresses.
REQ-009 Port rs_data, rt_data  output  DATA_W  read-port data (combinational).
REQ-010 Port we  input  1  write enable.
REQ-011 Port rd_addr  input  ADDR_W  write address.
REQ-012 Port wr_data  input  DATA_W  write data.
REQ-013 Port hlt  input  1  halt request (level).
REQ-014 Port cycle_count  output  CNT_W  running cycle counter.
REQ-015 Port busy  output  1  high while a dump is in progress.
REQ-016 Port dump_valid  output  1  the current dump word is valid.
REQ-017 Port dump_ready  input  1  the consumer accepts the dump word.
REQ-018 Port dump_idx  output  ADDR_W  index of the register being dumped.
REQ-019 Port dump_data  output  DATA_W  dump word.
REQ-020 Port dump_last  output  1  marks the final dump word (cycle count).

Function
REQ-021 Reads SHALL be combinational: rs_data = regs[rs_addr] and rt_data = regs[rt_addr].
REQ-022 When BYPASS=1 and an accepted write targets a read address in the same cycle, that read port SHALL output wr_data; when BYPASS=0 it SHALL output the old value until the next edge.
REQ-023 When ZERO_REG=1, address 0 SHALL read as 0 on both ports and in the dump, regardless of writes or bypass.
REQ-024 A write SHALL be accepted on a rising clk edge when we=1 and busy=0; writes while busy=1 SHALL be dropped.
REQ-025 cycle_count SHALL increment by 1 on every rising edge while the FSM is in RUN.
REQ-026 cycle_count SHALL saturate at 2**CNT_W-1 and SHALL NOT wrap.
REQ-027 The FSM SHALL have the states RUN, DUMP, CNT and HALTED.
REQ-028 RUN->DUMP SHALL occur on the first edge at which hlt=1, detected as a rising edge against a registered copy of hlt.
REQ-029 cycle_count SHALL freeze on that same edge.
REQ-030 On entry to DUMP, the dump pointer SHALL be 0.
REQ-031 In DUMP, dump_valid=1, dump_idx=pointer, dump_data=regs[pointer] and dump_last=0.
REQ-032 In DUMP, each edge with dump_ready=1 SHALL increment the pointer; the word SHALL be held while dump_ready=0.
REQ-033 The handshake on the pointer value 2**ADDR_W-1 SHALL move the FSM DUMP->CNT.
REQ-034 In CNT, dump_valid=1, dump_last=1, dump_idx=0 and dump_data=cycle_count[DATA_W-1:0], zero-extended if CNT_W<DATA_W.
REQ-035 A handshake in CNT SHALL move the FSM to HALTED.
REQ-036 busy SHALL be 1 in DUMP and CNT, and 0 in RUN and HALTED.
REQ-037 In HALTED: dump_valid=0, writes are accepted, and the counter stays frozen.
REQ-038 HALTED->RUN SHALL occur on the edge at which hlt is sampled 0; the count resumes from the frozen value.
REQ-039 hlt toggling during DUMP or CNT SHALL be ignored; the sequence always completes.
REQ-040 A write and a hlt rising edge on the same edge: the write SHALL be accepted, and the dump SHALL show the new value.
REQ-041 The dump SHALL emit exactly 2**ADDR_W+1 words per hlt rising edge.

Reset
REQ-042 While rst_n=0, asynchronously:
- all registers = 0, cycle_count = 0, pointer = 0, FSM = RUN;
- busy = 0, dump_valid = 0, dump_last = 0, dump_idx = 0, dump_data = 0;
- registered hlt copy = 0.
REQ-043 Reset asserted mid-dump SHALL abort the dump immediately, with no further dump_valid.
REQ-044 After rst_n deasserts, the first rising edge SHALL be a normal RUN cycle: count 0->1.

Verification
REQ-045 Scenario, bypass:
- stimulus: we=1, rd_addr=3, wr_data=16'hBEEF, rs_addr=3;
- response: rs_data=BEEF in the same cycle; with BYPASS=0, BEEF appears only after the edge.
REQ-046 Scenario, zero register:
- stimulus: write 16'h1234 to address 0;
- response: rs_data=0, rt_data=0, and dump word 0 = 0.
REQ-047 Scenario, dump with backpressure:
- stimulus: regs[i]=i*16'h0101; after 10 RUN cycles pulse hlt; toggle dump_ready 1,0,1,...;
- response: 17 words in order, idx 0..15, values 0000..0F0F, then dump_last=1 with data 000A;
- each word is held stable while dump_ready=0.
REQ-048 Scenario, write during dump:
- stimulus: we=1 to address 5 while busy=1;
- response: regs[5] is unchanged.
REQ-049 Scenario, saturation:
- stimulus: CNT_W=4, run 20 cycles;
- response: cycle_count=15 and stays 15.
REQ-050 Scenario, reset mid-dump:
- stimulus: assert rst_n=0 at dump word 7;
- response: busy=0, dump_valid=0 and cycle_count=0 immediately, with no clock edge needed;
- all registers read 0.
